// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Round-robin arbitration is selected at build time by MEM_ARB_RR_EN.
package mem_arb_pkg;

   localparam int unsigned READ_LAT_DEF = 2;
   localparam int unsigned AW           = 32;
   localparam int unsigned DW           = 32;
   localparam int unsigned CNT_W        = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_LS = 1'b1
   } req_id_e;

   // Access captured at grant time and replayed to memory during ACCESS
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      req_id_e       id;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store requesters.
// MEM_ARB_RR_EN: round-robin with a priority pointer; otherwise fixed ls-over-if.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    if_req,
   input  logic    ls_req,
   input  logic    grant,
   output logic    any_c,
   output req_id_e winner_c
);

   assign any_c = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
   req_id_e prio;

   // Priority goes to whichever requester was not granted last
   always_ff @(posedge clock) begin
      if (reset) begin
         prio <= REQ_LS;
      end else if (grant) begin
         prio <= (winner_c == REQ_LS) ? REQ_IF : REQ_LS;
      end
   end

   always_comb begin
      winner_c = REQ_LS;
      if (if_req && ls_req) begin
         winner_c = prio;
      end else if (if_req) begin
         winner_c = REQ_IF;
      end
   end
`else
   logic unused_pick;

   assign unused_pick = ^{clock, reset, grant};

   always_comb begin
      winner_c = REQ_LS;
      if (!ls_req && if_req) begin
         winner_c = REQ_IF;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter serving instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: fixed ls priority).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned READ_LAT = READ_LAT_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_valid,
   output logic [DW-1:0] if_rdata,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic          ls_gnt,
   output logic          ls_valid,
   output logic [DW-1:0] ls_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   state_e           state;
   state_e           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   mem_req_t         cur;
   mem_req_t         cur_nxt;
   logic             any_c;
   req_id_e          winner_c;
   logic             grant_c;
   logic             last_c;

   mem_arb_pick u_pick (
      .clock    (clock),
      .reset    (reset),
      .if_req   (if_req),
      .ls_req   (ls_req),
      .grant    (grant_c),
      .any_c    (any_c),
      .winner_c (winner_c)
   );

   // Final ACCESS cycle: read data is sampled on the closing edge
   assign last_c = (state == ST_ACCESS) && (cnt == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cur      <= '0;
         if_valid <= 1'b0;
         ls_valid <= 1'b0;
         if_rdata <= '0;
         ls_rdata <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         cur      <= cur_nxt;
         if_valid <= last_c && (cur.id == REQ_IF);
         ls_valid <= last_c && (cur.id == REQ_LS);
         if (last_c && !cur.we) begin
            if (cur.id == REQ_IF) begin
               if_rdata <= mem_rdata;
            end else begin
               ls_rdata <= mem_rdata;
            end
         end
      end
   end

   // Next state, grant and capture of the winning request
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cur_nxt   = cur;
      grant_c   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_c && !reset) begin
               grant_c    = 1'b1;
               cur_nxt.id = winner_c;
               if (winner_c == REQ_LS) begin
                  cur_nxt.we    = ls_we;
                  cur_nxt.addr  = ls_addr;
                  cur_nxt.wdata = ls_wdata;
               end else begin
                  cur_nxt.we    = 1'b0;
                  cur_nxt.addr  = if_addr;
                  cur_nxt.wdata = '0;
               end
               cnt_nxt   = cur_nxt.we ? '0 : CNT_W'(READ_LAT - 1);
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt == '0) begin
               state_nxt = ST_RESP;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign if_gnt    = grant_c && (winner_c == REQ_IF);
   assign ls_gnt    = grant_c && (winner_c == REQ_LS);
   assign busy      = (state != ST_IDLE);
   assign mem_addr  = (state == ST_ACCESS) ? {cur.addr[AW-1:2], 2'b00} : '0;
   assign mem_wr    = (state == ST_ACCESS) && cur.we;
   assign mem_wdata = mem_wr ? cur.wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a cycle-count reference model.
module tb_mem_arbiter;

   localparam int unsigned LAT = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_valid;
   logic [31:0] ls_rdata;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] dev_mem   [logic [29:0]];
   logic [31:0] model_mem [logic [29:0]];

   always #5 clock = ~clock;

   mem_arbiter #(.READ_LAT(LAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_valid  (if_valid),
      .if_rdata  (if_rdata),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_gnt    (ls_gnt),
      .ls_valid  (ls_valid),
      .ls_rdata  (ls_rdata),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   function automatic logic [31:0] init_word(input logic [29:0] w);
      return {w[15:0] ^ 16'hA5C3, ~w[15:0]};
   endfunction

   // Memory device: writes land and read data is presented mid-cycle
   always @(negedge clock) begin
      if (mem_wr) dev_mem[mem_addr[31:2]] = mem_wdata;
      mem_rdata = dev_mem.exists(mem_addr[31:2]) ? dev_mem[mem_addr[31:2]] : init_word(mem_addr[31:2]);
   end

   task automatic do_reset();
      reset = 1'b1; if_req = 1'b0; ls_req = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; if_req = 1'b1; ls_req = 1'b1;
      if_addr = 32'h40; ls_addr = 32'h44; ls_we = 1'b1; ls_wdata = 32'h1234_5678;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_cmp++; if ({if_gnt, ls_gnt} !== 2'b00) begin n_bad++; $display("FAIL rst_gnt: got %b expected 00", {if_gnt, ls_gnt}); end
      n_cmp++; if ({if_valid, ls_valid, busy, mem_wr} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b expected 0000", {if_valid, ls_valid, busy, mem_wr}); end
      n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem: got %h/%h expected 0/0", mem_addr, mem_wdata); end
      n_cmp++; if (if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h/%h expected 0/0", if_rdata, ls_rdata); end
      @(posedge clock); #1;
      reset = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
   endtask

   task automatic test_fetch();
      dev_mem[30'd2] = 32'h2002_0004; model_mem[30'd2] = 32'h2002_0004;
      @(posedge clock); #1;
      if_req = 1'b1; if_addr = 32'h8;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) begin @(posedge clock); #1; end
         if (k == 1) if_req = 1'b0;
         @(negedge clock);
         n_cmp++; if (if_gnt !== (k == 0) || ls_gnt !== 1'b0) begin n_bad++; $display("FAIL fetch_gnt k=%0d: got %b%b expected %b0", k, if_gnt, ls_gnt, k == 0); end
         n_cmp++; if (mem_addr !== ((k == 1 || k == 2) ? 32'h8 : 32'h0)) begin n_bad++; $display("FAIL fetch_addr k=%0d: got %h", k, mem_addr); end
         n_cmp++; if (busy !== (k >= 1 && k <= 3)) begin n_bad++; $display("FAIL fetch_busy k=%0d: got %b", k, busy); end
         n_cmp++; if (if_valid !== (k == 3) || ls_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_valid k=%0d: got %b%b", k, if_valid, ls_valid); end
         if (k == 3) begin
            n_cmp++; if (if_rdata !== 32'h2002_0004) begin n_bad++; $display("FAIL fetch_rdata: got %h expected 20020004", if_rdata); end
         end
      end
   endtask

   task automatic test_store();
      @(posedge clock); #1;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h13; ls_wdata = 32'hDEAD_BEEF;
      model_mem[30'd4] = 32'hDEAD_BEEF;
      for (int k = 0; k <= 3; k++) begin
         if (k > 0) begin @(posedge clock); #1; end
         if (k == 1) begin ls_req = 1'b0; ls_we = 1'b0; end
         @(negedge clock);
         n_cmp++; if (ls_gnt !== (k == 0) || if_gnt !== 1'b0) begin n_bad++; $display("FAIL store_gnt k=%0d: got %b%b", k, ls_gnt, if_gnt); end
         n_cmp++; if (mem_addr !== ((k == 1) ? 32'h10 : 32'h0) || mem_wr !== (k == 1)) begin n_bad++; $display("FAIL store_mem k=%0d: got %h wr=%b", k, mem_addr, mem_wr); end
         n_cmp++; if (mem_wdata !== ((k == 1) ? 32'hDEAD_BEEF : 32'h0)) begin n_bad++; $display("FAIL store_wdata k=%0d: got %h", k, mem_wdata); end
         n_cmp++; if (ls_valid !== (k == 2) || if_valid !== 1'b0) begin n_bad++; $display("FAIL store_valid k=%0d: got %b%b", k, ls_valid, if_valid); end
      end
      n_cmp++; if (ls_rdata !== 32'h0) begin n_bad++; $display("FAIL store_rdata: got %h expected 0", ls_rdata); end
   endtask

   task automatic test_simultaneous();
      logic [1:0] exp_seq [3];
      int w;
`ifdef MEM_ARB_RR_EN
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10;
`else
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10;
`endif
      do_reset();
      if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h8;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) begin @(posedge clock); #1; end
         if (k == 1) ls_req = 1'b0;
         if (k == 5) if_req = 1'b0;
         @(negedge clock);
         n_cmp++; if ({ls_gnt, if_gnt} !== {k == 0, k == 4}) begin n_bad++; $display("FAIL sim_gnt k=%0d: got %b%b expected %b%b", k, ls_gnt, if_gnt, k == 0, k == 4); end
         n_cmp++; if ({ls_valid, if_valid} !== {k == 3, k == 7}) begin n_bad++; $display("FAIL sim_valid k=%0d: got %b%b", k, ls_valid, if_valid); end
         if (k == 3) begin
            n_cmp++; if (ls_rdata !== 32'h2002_0004) begin n_bad++; $display("FAIL sim_ls_rdata: got %h expected 20020004", ls_rdata); end
         end
         if (k == 7) begin
            n_cmp++; if (if_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sim_if_rdata: got %h expected deadbeef", if_rdata); end
         end
      end
      @(posedge clock); #1;
      if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h20; ls_addr = 32'h24;
      for (int r = 0; r < 3; r++) begin
         w = 0;
         @(negedge clock);
         while (!(if_gnt || ls_gnt) && w < 20) begin @(negedge clock); w++; end
         n_cmp++;
         if (w >= 20) begin n_bad++; $display("FAIL sim_rr_timeout r=%0d: no grant within 20 cycles", r); end
         else if ({ls_gnt, if_gnt} !== exp_seq[r]) begin n_bad++; $display("FAIL sim_rr r=%0d: got %b%b expected %b", r, ls_gnt, if_gnt, exp_seq[r]); end
         @(posedge clock); #1;
      end
      if_req = 1'b0; ls_req = 1'b0;
      w = 0;
      @(negedge clock);
      while (busy && w < 20) begin @(negedge clock); w++; end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sim_drain: busy got %b expected 0", busy); end
   endtask

   task automatic test_reset_abort();
      @(posedge clock); #1;
      if_req = 1'b1; if_addr = 32'h10;
      @(negedge clock);
      n_cmp++; if (if_gnt !== 1'b1) begin n_bad++; $display("FAIL abort_gnt: got %b expected 1", if_gnt); end
      @(posedge clock); #1;
      if_req = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      n_cmp++; if ({busy, if_valid, ls_valid, if_gnt, ls_gnt, mem_wr} !== 6'b0) begin n_bad++; $display("FAIL abort_flags: got %b expected 000000", {busy, if_valid, ls_valid, if_gnt, ls_gnt, mem_wr}); end
      n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL abort_mem: got %h/%h expected 0/0", mem_addr, mem_wdata); end
      n_cmp++; if (if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin n_bad++; $display("FAIL abort_rdata: got %h/%h expected 0/0", if_rdata, ls_rdata); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         n_cmp++; if (if_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_quiet k=%0d: valid=%b busy=%b expected 0/0", k, if_valid, busy); end
      end
   endtask

   task automatic test_drop();
      @(posedge clock); #1;
      if_req = 1'b1; if_addr = 32'h4;
      for (int k = 0; k <= 7; k++) begin
         if (k > 0) begin @(posedge clock); #1; end
         if (k == 1) begin if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30; ls_wdata = 32'hCAFE_F00D; end
         if (k == 2) begin ls_req = 1'b0; ls_we = 1'b0; end
         @(negedge clock);
         n_cmp++; if (ls_gnt !== 1'b0 || if_gnt !== (k == 0)) begin n_bad++; $display("FAIL drop_gnt k=%0d: got %b%b", k, ls_gnt, if_gnt); end
         n_cmp++; if (mem_wr !== 1'b0 || mem_addr !== ((k == 1 || k == 2) ? 32'h4 : 32'h0)) begin n_bad++; $display("FAIL drop_mem k=%0d: got %h wr=%b", k, mem_addr, mem_wr); end
         n_cmp++; if (busy !== (k >= 1 && k <= 3) || ls_valid !== 1'b0) begin n_bad++; $display("FAIL drop_busy k=%0d: busy=%b ls_valid=%b", k, busy, ls_valid); end
      end
   endtask

   task automatic test_random(input int ncyc);
      logic        ip, lp, gi_prev, gl_prev, last_ls, win_ls, tid, twe;
      logic        exp_gi, exp_gl, exp_busy, in_acc, resp, exp_wr;
      logic [31:0] taddr, twdata, tdata, exp_ifd, exp_lsd, exp_addr, exp_wd;
      int          g, tlat, last_busy;
      ip = 1'b0; lp = 1'b0; gi_prev = 1'b0; gl_prev = 1'b0; last_ls = 1'b0;
      tid = 1'b0; twe = 1'b0; taddr = 32'h0; twdata = 32'h0; tdata = 32'h0;
      exp_ifd = 32'h0; exp_lsd = 32'h0; g = -100; tlat = 1; last_busy = -1;
      do_reset();
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clock); #1;
         if (gi_prev) ip = 1'b0;
         if (gl_prev) lp = 1'b0;
         if (c < ncyc - 16) begin
            if (!ip) begin
               if ($urandom_range(0, 3) == 0) begin ip = 1'b1; if_addr = 32'($urandom_range(0, 63)); end
            end else if ($urandom_range(0, 19) == 0) ip = 1'b0;
            if (!lp) begin
               if ($urandom_range(0, 3) == 0) begin
                  lp = 1'b1; ls_we = 1'($urandom_range(0, 1));
                  ls_addr = 32'($urandom_range(0, 63)); ls_wdata = $urandom;
               end
            end else if ($urandom_range(0, 19) == 0) lp = 1'b0;
         end else begin
            ip = 1'b0; lp = 1'b0;
         end
         if_req = ip; ls_req = lp;
         @(negedge clock);
         exp_gi = 1'b0; exp_gl = 1'b0;
         if (c > last_busy && (ip || lp)) begin
`ifdef MEM_ARB_RR_EN
            win_ls = lp && (!ip || !last_ls);
`else
            win_ls = lp;
`endif
            g = c; tid = win_ls; last_ls = win_ls;
            twe = win_ls ? ls_we : 1'b0;
            taddr = win_ls ? ls_addr : if_addr;
            twdata = ls_wdata;
            tlat = twe ? 1 : int'(LAT);
            last_busy = c + tlat + 1;
            if (twe) model_mem[taddr[31:2]] = twdata;
            else tdata = model_mem.exists(taddr[31:2]) ? model_mem[taddr[31:2]] : init_word(taddr[31:2]);
            exp_gl = win_ls; exp_gi = !win_ls;
         end
         gi_prev = exp_gi; gl_prev = exp_gl;
         in_acc   = (c >= g + 1) && (c <= g + tlat);
         resp     = (c == g + tlat + 1);
         exp_busy = (c > g) && (c <= g + tlat + 1);
         exp_addr = in_acc ? {taddr[31:2], 2'b00} : 32'h0;
         exp_wr   = in_acc && twe;
         exp_wd   = exp_wr ? twdata : 32'h0;
         if (resp && !twe) begin
            if (tid) exp_lsd = tdata;
            else exp_ifd = tdata;
         end
         n_cmp++; if ({if_gnt, ls_gnt} !== {exp_gi, exp_gl}) begin n_bad++; $display("FAIL rnd_gnt c=%0d: got %b%b expected %b%b", c, if_gnt, ls_gnt, exp_gi, exp_gl); end
         n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, exp_busy); end
         n_cmp++; if (mem_addr !== exp_addr || mem_wr !== exp_wr || mem_wdata !== exp_wd) begin n_bad++; $display("FAIL rnd_mem c=%0d: got %h/%b/%h expected %h/%b/%h", c, mem_addr, mem_wr, mem_wdata, exp_addr, exp_wr, exp_wd); end
         n_cmp++; if ({if_valid, ls_valid} !== {resp && !tid, resp && tid}) begin n_bad++; $display("FAIL rnd_valid c=%0d: got %b%b expected %b%b", c, if_valid, ls_valid, resp && !tid, resp && tid); end
         n_cmp++; if (if_rdata !== exp_ifd || ls_rdata !== exp_lsd) begin n_bad++; $display("FAIL rnd_rdata c=%0d: got %h/%h expected %h/%h", c, if_rdata, ls_rdata, exp_ifd, exp_lsd); end
      end
   endtask

   initial begin
      reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
      test_reset();
      test_fetch();
      test_store();
      test_simultaneous();
      test_reset_abort();
      test_drop();
      test_random(3000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
